// File: rtl/riscv_pkg.sv
// RV32I decode support package: opcode constants, ALU op enum, immediate
// format enum and small funct3 -> ALU op helpers.
// Build option DECODE_M_EXT_EN (consumed in decode_unit) enables RV32M decode.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef INVALID_PC
`define INVALID_PC {`XLEN{1'b1}}
`endif

package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_PASS   = 5'd10,  // result = immediate (LUI)
        ALU_SYS    = 5'd11,
        ALU_MUL    = 5'd12,
        ALU_MULH   = 5'd13,
        ALU_MULHSU = 5'd14,
        ALU_MULHU  = 5'd15,
        ALU_DIV    = 5'd16,
        ALU_DIVU   = 5'd17,
        ALU_REM    = 5'd18,
        ALU_REMU   = 5'd19
    } alu_op_e;

    // FMT_R means "no immediate"; it also drives which source regs are read.
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } imm_fmt_e;

    // Integer ALU op for OP/OP-IMM; alt selects SUB/SRA.
    function automatic alu_op_e base_alu(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // RV32M op for OP with funct7 = 0000001.
    function automatic alu_op_e m_alu(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return ALU_MUL;
            3'b001:  return ALU_MULH;
            3'b010:  return ALU_MULHSU;
            3'b011:  return ALU_MULHU;
            3'b100:  return ALU_DIV;
            3'b101:  return ALU_DIVU;
            3'b110:  return ALU_REM;
            default: return ALU_REMU;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: picks the immediate bits for the given format and
// sign-extends from instruction bit 31 to XLEN.
module imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = `XLEN
) (
    input  logic [31:7]     i_inst,
    input  imm_fmt_e        i_fmt,
    output logic [XLEN-1:0] o_imm
);

    logic [31:0] imm32;

    // Assemble the 32-bit immediate for the selected format
    always_comb begin
        imm32 = '0;
        case (i_fmt)
            FMT_I:   imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
            FMT_S:   imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            FMT_B:   imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                              i_inst[30:25], i_inst[11:8], 1'b0};
            FMT_U:   imm32 = {i_inst[31:12], 12'b0};
            FMT_J:   imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                              i_inst[20], i_inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign o_imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_unit.sv
// RV32I decode stage: decodes the fetch instruction, reads operands from the
// register file, detects load-use hazards and registers one micro-op for
// execute. Define DECODE_M_EXT_EN to decode RV32M ops; otherwise they are
// flagged illegal.
module decode_unit
    import riscv_pkg::*;
#(
    parameter int          XLEN     = `XLEN,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     i_fu_inst,
    input  logic [XLEN-1:0] i_fu_addr,
    input  logic            i_fu_branch_taken,
    output logic            o_fu_stall,
    output logic [4:0]      o_rf_rs1_addr,
    output logic [4:0]      o_rf_rs2_addr,
    input  logic [XLEN-1:0] i_rf_rs1_data,
    input  logic [XLEN-1:0] i_rf_rs2_data,
    input  logic            i_exec_flush,
    input  logic            i_exec_busy,
    output logic            o_exec_valid,
    output logic [XLEN-1:0] o_exec_pc,
    output alu_op_e         o_exec_alu_op,
    output logic [XLEN-1:0] o_exec_rs1_data,
    output logic [XLEN-1:0] o_exec_rs2_data,
    output logic [XLEN-1:0] o_exec_imm,
    output logic [4:0]      o_exec_rd,
    output logic            o_exec_rd_we,
    output logic            o_exec_is_load,
    output logic            o_exec_is_store,
    output logic            o_exec_is_branch,
    output logic            o_exec_is_jump,
    output logic [2:0]      o_exec_mem_funct3,
    output logic            o_exec_branch_taken,
    output logic            o_exec_illegal
);

    localparam logic [XLEN-1:0] INVALID_PC = XLEN'(`INVALID_PC);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        alu_op_e         alu_op;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic            rd_we;
        logic            is_load;
        logic            is_store;
        logic            is_branch;
        logic            is_jump;
        logic [2:0]      mem_funct3;
        logic            branch_taken;
        logic            illegal;
    } exec_op_t;

    // Empty slot: what reset, flush and bubbles leave in the output register.
    function automatic exec_op_t empty_op();
        exec_op_t op;
        op    = '0;
        op.pc = INVALID_PC;
        return op;
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_field;

    assign opcode   = i_fu_inst[6:0];
    assign funct3   = i_fu_inst[14:12];
    assign funct7   = i_fu_inst[31:25];
    assign rd_field = i_fu_inst[11:7];

    assign o_rf_rs1_addr = i_fu_inst[19:15];
    assign o_rf_rs2_addr = i_fu_inst[24:20];

    imm_fmt_e        fmt;
    alu_op_e         alu_op;
    logic            legal;
    logic            writes_rd;
    logic            cls_load;
    logic            cls_store;
    logic            cls_branch;
    logic            cls_jump;
    logic [XLEN-1:0] imm;
    logic            bubble;
    logic            hazard;
    logic            uses_rs1;
    logic            uses_rs2;
    exec_op_t        dec;
    exec_op_t        op_d;
    exec_op_t        op_q;

    assign bubble = (i_fu_addr == INVALID_PC) || (i_fu_inst == NOP_INST);

    // Classify the opcode, choose the ALU op and check funct3/funct7 legality
    always_comb begin
        fmt        = FMT_R;
        alu_op     = ALU_ADD;
        legal      = 1'b1;
        writes_rd  = 1'b0;
        cls_load   = 1'b0;
        cls_store  = 1'b0;
        cls_branch = 1'b0;
        cls_jump   = 1'b0;
        case (opcode)
            OPC_LUI: begin
                fmt       = FMT_U;
                alu_op    = ALU_PASS;
                writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                fmt       = FMT_U;
                writes_rd = 1'b1;
            end
            OPC_JAL: begin
                fmt       = FMT_J;
                writes_rd = 1'b1;
                cls_jump  = 1'b1;
            end
            OPC_JALR: begin
                fmt       = FMT_I;
                writes_rd = 1'b1;
                cls_jump  = 1'b1;
                legal     = (funct3 == 3'b000);
            end
            OPC_BRANCH: begin
                fmt        = FMT_B;
                cls_branch = 1'b1;
                case (funct3)
                    3'b000, 3'b001: alu_op = ALU_SUB;
                    3'b100, 3'b101: alu_op = ALU_SLT;
                    3'b110, 3'b111: alu_op = ALU_SLTU;
                    default:        legal  = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                fmt       = FMT_I;
                cls_load  = 1'b1;
                writes_rd = 1'b1;
                legal     = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                            (funct3 == 3'b010) || (funct3 == 3'b100) ||
                            (funct3 == 3'b101);
            end
            OPC_STORE: begin
                fmt       = FMT_S;
                cls_store = 1'b1;
                legal     = (funct3 <= 3'b010);
            end
            OPC_OPIMM: begin
                fmt       = FMT_I;
                writes_rd = 1'b1;
                alu_op    = base_alu(funct3, (funct3 == 3'b101) && funct7[5]);
                if (funct3 == 3'b001)
                    legal = (funct7 == 7'b0000000);
                else if (funct3 == 3'b101)
                    legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            end
            OPC_OP: begin
                writes_rd = 1'b1;
                case (funct7)
                    7'b0000000: alu_op = base_alu(funct3, 1'b0);
                    7'b0100000: begin
                        alu_op = base_alu(funct3, 1'b1);
                        legal  = (funct3 == 3'b000) || (funct3 == 3'b101);
                    end
                    7'b0000001: begin
`ifdef DECODE_M_EXT_EN
                        alu_op = m_alu(funct3);
`else
                        legal  = 1'b0;
`endif
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_FENCE: begin
                // FENCE / FENCE.I retire as a valid no-op.
                fmt   = FMT_I;
                legal = (funct3 == 3'b000) || (funct3 == 3'b001);
            end
            OPC_SYSTEM: begin
                // funct3 != 0 are CSR ops, which return a value in rd.
                fmt       = FMT_I;
                alu_op    = ALU_SYS;
                writes_rd = (funct3 != 3'b000);
                legal     = (funct3 != 3'b100);
            end
            default: legal = 1'b0;
        endcase
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .i_inst (i_fu_inst[31:7]),
        .i_fmt  (fmt),
        .o_imm  (imm)
    );

    // Build the micro-op; an illegal instruction carries no side effects
    always_comb begin
        dec = empty_op();
        if (!bubble) begin
            dec.valid        = 1'b1;
            dec.pc           = i_fu_addr;
            dec.branch_taken = i_fu_branch_taken;
            dec.rs1_data     = i_rf_rs1_data;
            dec.rs2_data     = i_rf_rs2_data;
            dec.imm          = imm;
            if (legal) begin
                dec.alu_op     = alu_op;
                dec.rd         = writes_rd ? rd_field : 5'd0;
                dec.rd_we      = writes_rd && (rd_field != 5'd0);
                dec.is_load    = cls_load;
                dec.is_store   = cls_store;
                dec.is_branch  = cls_branch;
                dec.is_jump    = cls_jump;
                // Branches also carry funct3 so execute knows the condition.
                dec.mem_funct3 = (cls_load || cls_store || cls_branch) ? funct3 : 3'd0;
            end else begin
                dec.illegal = 1'b1;
            end
        end
    end

    assign uses_rs1 = (fmt != FMT_U) && (fmt != FMT_J);
    assign uses_rs2 = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);

    assign hazard = op_q.valid && op_q.is_load && (op_q.rd != 5'd0) && !bubble &&
                    ((uses_rs1 && (o_rf_rs1_addr == op_q.rd)) ||
                     (uses_rs2 && (o_rf_rs2_addr == op_q.rd)));

    assign o_fu_stall = (hazard || i_exec_busy) && !i_exec_flush;

    // Output register next state: flush > busy hold > hazard bubble > capture
    always_comb begin
        op_d = op_q;
        if (i_exec_flush)
            op_d = empty_op();
        else if (i_exec_busy)
            op_d = op_q;
        else if (hazard)
            op_d = empty_op();
        else
            op_d = dec;
    end

    // Output register with synchronous reset to an empty slot
    always_ff @(posedge clk) begin
        if (rst)
            op_q <= empty_op();
        else
            op_q <= op_d;
    end

    assign o_exec_valid        = op_q.valid;
    assign o_exec_pc           = op_q.pc;
    assign o_exec_alu_op       = op_q.alu_op;
    assign o_exec_rs1_data     = op_q.rs1_data;
    assign o_exec_rs2_data     = op_q.rs2_data;
    assign o_exec_imm          = op_q.imm;
    assign o_exec_rd           = op_q.rd;
    assign o_exec_rd_we        = op_q.rd_we;
    assign o_exec_is_load      = op_q.is_load;
    assign o_exec_is_store     = op_q.is_store;
    assign o_exec_is_branch    = op_q.is_branch;
    assign o_exec_is_jump      = op_q.is_jump;
    assign o_exec_mem_funct3   = op_q.mem_funct3;
    assign o_exec_branch_taken = op_q.branch_taken;
    assign o_exec_illegal      = op_q.illegal;

endmodule

// File: tb/tb_decode_unit.sv
// Directed self-checking bench for decode_unit (RV32I decode stage).
`ifndef XLEN
`define XLEN 32
`endif
`ifndef INVALID_PC
`define INVALID_PC {`XLEN{1'b1}}
`endif

module tb_decode_unit;

    localparam logic [31:0] INV = `INVALID_PC;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fu_inst, fu_addr;
    logic        fu_bt, flush, busy;
    logic        stall;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        valid;
    logic [31:0] pc, rs1_o, rs2_o, imm;
    logic [4:0]  alu_op, rd;
    logic        rd_we, is_load, is_store, is_branch, is_jump, bt_o, illegal;
    logic [2:0]  mf3;

    int nvec = 0;
    int nerr = 0;

    // Register file model: xN reads as 0x1000 + N.
    assign rs1_data = 32'h1000 + {27'd0, rs1_addr};
    assign rs2_data = 32'h1000 + {27'd0, rs2_addr};

    always #5 clk = ~clk;

    decode_unit dut (
        .clk(clk), .rst(rst),
        .i_fu_inst(fu_inst), .i_fu_addr(fu_addr), .i_fu_branch_taken(fu_bt),
        .o_fu_stall(stall),
        .o_rf_rs1_addr(rs1_addr), .o_rf_rs2_addr(rs2_addr),
        .i_rf_rs1_data(rs1_data), .i_rf_rs2_data(rs2_data),
        .i_exec_flush(flush), .i_exec_busy(busy),
        .o_exec_valid(valid), .o_exec_pc(pc), .o_exec_alu_op(alu_op),
        .o_exec_rs1_data(rs1_o), .o_exec_rs2_data(rs2_o), .o_exec_imm(imm),
        .o_exec_rd(rd), .o_exec_rd_we(rd_we),
        .o_exec_is_load(is_load), .o_exec_is_store(is_store),
        .o_exec_is_branch(is_branch), .o_exec_is_jump(is_jump),
        .o_exec_mem_funct3(mf3), .o_exec_branch_taken(bt_o),
        .o_exec_illegal(illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] addr, input logic bt);
        fu_inst = inst;
        fu_addr = addr;
        fu_bt   = bt;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; busy = 1'b0;
        drive(32'h0050_0093, 32'h0000_0100, 1'b1);
        tick();
        nvec++;
        if ({valid, pc} !== {1'b0, INV}) begin
            nerr++; $display("FAIL reset_valid_pc got %b/%h exp 0/%h", valid, pc, INV);
        end
        nvec++;
        if ({alu_op, rd, rd_we, is_load, is_store, is_branch, is_jump, mf3, bt_o, illegal} !== 20'd0) begin
            nerr++; $display("FAIL reset_fields got alu=%0d rd=%0d we=%b ld=%b st=%b br=%b j=%b f3=%0d bt=%b ill=%b exp all 0",
                             alu_op, rd, rd_we, is_load, is_store, is_branch, is_jump, mf3, bt_o, illegal);
        end
        nvec++;
        if ({imm, rs1_o, rs2_o} !== 96'd0) begin
            nerr++; $display("FAIL reset_data got imm=%h rs1=%h rs2=%h exp 0", imm, rs1_o, rs2_o);
        end
        nvec++;
        if (stall !== 1'b0) begin
            nerr++; $display("FAIL reset_stall got %b exp 0", stall);
        end
        rst = 1'b0;
    endtask

    task automatic test_addi();
        drive(32'h0050_0093, 32'h0000_0100, 1'b0);   // addi x1,x0,5
        tick();
        nvec++;
        if ({valid, imm, rd, rd_we, alu_op, pc} !== {1'b1, 32'd5, 5'd1, 1'b1, 5'd0, 32'h100}) begin
            nerr++; $display("FAIL addi got v=%b imm=%h rd=%0d we=%b alu=%0d pc=%h exp 1/5/1/1/0/100",
                             valid, imm, rd, rd_we, alu_op, pc);
        end
        nvec++;
        if ({rs1_o, illegal, is_load} !== {32'h1000, 1'b0, 1'b0}) begin
            nerr++; $display("FAIL addi_ops got rs1=%h ill=%b ld=%b exp 1000/0/0", rs1_o, illegal, is_load);
        end
    endtask

    task automatic test_load_use();
        drive(32'h0000_A103, 32'h0000_0104, 1'b0);   // lw x2,0(x1)
        tick();
        nvec++;
        if ({valid, is_load, rd, rd_we, mf3, imm} !== {1'b1, 1'b1, 5'd2, 1'b1, 3'd2, 32'd0}) begin
            nerr++; $display("FAIL lw got v=%b ld=%b rd=%0d we=%b f3=%0d imm=%h exp 1/1/2/1/2/0",
                             valid, is_load, rd, rd_we, mf3, imm);
        end
        drive(32'h0011_01B3, 32'h0000_0108, 1'b0);   // add x3,x2,x1
        #1;
        nvec++;
        if ({stall, rs1_addr, rs2_addr} !== {1'b1, 5'd2, 5'd1}) begin
            nerr++; $display("FAIL lu_stall got st=%b rs1=%0d rs2=%0d exp 1/2/1", stall, rs1_addr, rs2_addr);
        end
        tick();
        nvec++;
        if ({valid, stall} !== 2'b00) begin
            nerr++; $display("FAIL lu_bubble got v=%b st=%b exp 0/0", valid, stall);
        end
        tick();
        nvec++;
        if ({valid, pc, alu_op, rd, rd_we} !== {1'b1, 32'h108, 5'd0, 5'd3, 1'b1}) begin
            nerr++; $display("FAIL lu_issue got v=%b pc=%h alu=%0d rd=%0d we=%b exp 1/108/0/3/1",
                             valid, pc, alu_op, rd, rd_we);
        end
        nvec++;
        if ({rs1_o, rs2_o} !== {32'h1002, 32'h1001}) begin
            nerr++; $display("FAIL lu_ops got rs1=%h rs2=%h exp 1002/1001", rs1_o, rs2_o);
        end
    endtask

    task automatic test_branch();
        drive(32'hFE00_0CE3, 32'h0000_0200, 1'b1);   // beq x0,x0,-8
        tick();
        nvec++;
        if ({valid, is_branch, imm, bt_o, rd_we, is_jump, illegal} !==
            {1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            nerr++; $display("FAIL beq got v=%b br=%b imm=%h bt=%b we=%b j=%b ill=%b exp 1/1/fffffff8/1/0/0/0",
                             valid, is_branch, imm, bt_o, rd_we, is_jump, illegal);
        end
    endtask

    task automatic test_busy_flush();
        drive(32'h0050_0093, 32'h0000_0300, 1'b0);
        busy = 1'b1;
        #1;
        nvec++;
        if (stall !== 1'b1) begin
            nerr++; $display("FAIL busy1_stall got %b exp 1", stall);
        end
        tick();
        nvec++;
        if ({valid, pc, is_branch} !== {1'b1, 32'h200, 1'b1}) begin
            nerr++; $display("FAIL busy1_hold got v=%b pc=%h br=%b exp 1/200/1", valid, pc, is_branch);
        end
        flush = 1'b1;
        #1;
        nvec++;
        if (stall !== 1'b0) begin
            nerr++; $display("FAIL busy_flush_stall got %b exp 0", stall);
        end
        tick();
        flush = 1'b0;
        nvec++;
        if ({valid, pc, is_branch} !== {1'b0, INV, 1'b0}) begin
            nerr++; $display("FAIL flush got v=%b pc=%h br=%b exp 0/%h/0", valid, pc, is_branch, INV);
        end
        #1;
        nvec++;
        if (stall !== 1'b1) begin
            nerr++; $display("FAIL busy3_stall got %b exp 1", stall);
        end
        tick();
        busy = 1'b0;
        nvec++;
        if (valid !== 1'b0) begin
            nerr++; $display("FAIL busy3_hold got v=%b exp 0", valid);
        end
        tick();
        nvec++;
        if ({valid, pc} !== {1'b1, 32'h300}) begin
            nerr++; $display("FAIL busy_release got v=%b pc=%h exp 1/300", valid, pc);
        end
    endtask

    task automatic test_mul();
        drive(32'h0220_81B3, 32'h0000_0400, 1'b0);   // mul x3,x1,x2
        tick();
`ifdef DECODE_M_EXT_EN
        nvec++;
        if ({valid, alu_op, illegal, rd_we, rd} !== {1'b1, 5'd12, 1'b0, 1'b1, 5'd3}) begin
            nerr++; $display("FAIL mul got v=%b alu=%0d ill=%b we=%b rd=%0d exp 1/12/0/1/3",
                             valid, alu_op, illegal, rd_we, rd);
        end
`else
        nvec++;
        if ({valid, illegal, rd_we} !== 3'b110) begin
            nerr++; $display("FAIL mul got v=%b ill=%b we=%b exp 1/1/0", valid, illegal, rd_we);
        end
`endif
    endtask

    task automatic test_illegal();
        drive(32'h0000_007F, 32'h0000_0500, 1'b0);   // unknown opcode
        tick();
        nvec++;
        if ({valid, illegal, rd_we, is_load} !== 4'b1100) begin
            nerr++; $display("FAIL bad_opc got v=%b ill=%b we=%b ld=%b exp 1/1/0/0", valid, illegal, rd_we, is_load);
        end
    endtask

    task automatic test_bubbles();
        drive(32'h0000_A103, 32'h0000_0600, 1'b0);   // lw x2 registered
        tick();
        drive(32'h0011_01B3, INV, 1'b0);             // add reading x2, invalid pc
        #1;
        nvec++;
        if (stall !== 1'b0) begin
            nerr++; $display("FAIL invpc_stall got %b exp 0", stall);
        end
        tick();
        nvec++;
        if ({valid, pc} !== {1'b0, INV}) begin
            nerr++; $display("FAIL invpc_valid got v=%b pc=%h exp 0/%h", valid, pc, INV);
        end
        drive(32'h0000_0013, 32'h0000_0604, 1'b0);   // canonical nop
        tick();
        nvec++;
        if (valid !== 1'b0) begin
            nerr++; $display("FAIL nop_valid got %b exp 0", valid);
        end
    endtask

    task automatic test_flush_hazard();
        drive(32'h0000_A103, 32'h0000_0700, 1'b0);
        tick();
        drive(32'h0011_01B3, 32'h0000_0704, 1'b0);
        flush = 1'b1;
        #1;
        nvec++;
        if (stall !== 1'b0) begin
            nerr++; $display("FAIL flush_haz_stall got %b exp 0", stall);
        end
        tick();
        flush = 1'b0;
        nvec++;
        if ({valid, is_load} !== 2'b00) begin
            nerr++; $display("FAIL flush_haz got v=%b ld=%b exp 0/0", valid, is_load);
        end
        tick();
        nvec++;
        if ({valid, pc, rd} !== {1'b1, 32'h704, 5'd3}) begin
            nerr++; $display("FAIL flush_haz_issue got v=%b pc=%h rd=%0d exp 1/704/3", valid, pc, rd);
        end
    endtask

    task automatic test_reset_mid_stall();
        drive(32'h0000_A103, 32'h0000_0800, 1'b0);
        tick();
        drive(32'h0011_01B3, 32'h0000_0804, 1'b0);
        #1;
        nvec++;
        if (stall !== 1'b1) begin
            nerr++; $display("FAIL rst_mid_pre got %b exp 1", stall);
        end
        rst = 1'b1;
        tick();
        nvec++;
        if ({valid, pc, is_load, stall} !== {1'b0, INV, 1'b0, 1'b0}) begin
            nerr++; $display("FAIL rst_mid got v=%b pc=%h ld=%b st=%b exp 0/%h/0/0", valid, pc, is_load, stall, INV);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_use();
        test_branch();
        test_busy_flush();
        test_mul();
        test_illegal();
        test_bubbles();
        test_flush_hazard();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
